ysyx_22051013_axi_lsu_read_master: RTL and testbench

- AXI4-Lite-style read initiator for the LSU (MEM stage) side of the pipelined CPU.
- Accepts one load request from the pipeline and issues an 8-byte-aligned AR beat. It then accepts the R beat, extracts the addressed byte/half/word/dword and sign- or zero-extends it.
- Returns the result to the pipeline through a valid/ready response.
- Drives the LSU read slave (memory model) on the same ar/r channel set.

---
 rtl/ysyx_22051013_axi_lsu_read_master_pkg.sv | 47 ++++
 rtl/ysyx_22051013_axi_lsu_read_master_align.sv | 41 ++++
 rtl/ysyx_22051013_axi_lsu_read_master.sv | 154 +++++++++++++++
 tb/tb_ysyx_22051013_axi_lsu_read_master.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22051013_axi_lsu_read_master_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22051013_axi_lsu_read_master_pkg
//   Shared constants and types for the LSU AXI read master:
//   - reset-active level, LSU access-size encodings, AXI RESP constants
//   - read-master FSM state encoding
//   - latched request attributes (offset within the dword, size, unsigned)
//   - misalignment helper
// ----------------------------------------------------------------------------
package ysyx_22051013_axi_lsu_read_master_pkg;

  // Reset is active when rst equals this level.
  localparam logic ysyx_22051013_RSTABLE = 1'b1;

  // LSU access sizes.
  localparam logic [1:0] ysyx_22051013_LS_B = 2'd0;
  localparam logic [1:0] ysyx_22051013_LS_H = 2'd1;
  localparam logic [1:0] ysyx_22051013_LS_W = 2'd2;
  localparam logic [1:0] ysyx_22051013_LS_D = 2'd3;

  // AXI response field.
  localparam int         ysyx_22051013_RESP_W = 2;
  localparam logic [1:0] ysyx_22051013_OKAY   = 2'b00;

  // Read master states. S_IDLE/S_DATA keep their existing AXI encodings,
  // S_ADDR/S_RESP fill the remaining two codes.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } rd_state_e;

  // Attributes of the accepted load, held until the response returns.
  typedef struct packed {
    logic [2:0] off;
    logic [1:0] size;
    logic       uns;
  } ld_meta_t;

  // Natural alignment check for the requested size.
  function automatic logic ls_misaligned(input logic [1:0] size, input logic [2:0] off);
    return ((size == ysyx_22051013_LS_H) &&  off[0])          ||
           ((size == ysyx_22051013_LS_W) && (off[1:0] != 2'b0)) ||
           ((size == ysyx_22051013_LS_D) && (off      != 3'b0));
  endfunction

endpackage

// File: rtl/ysyx_22051013_axi_lsu_read_master_align.sv
// ----------------------------------------------------------------------------
// ysyx_22051013_lsu_load_align
//   Combinational load aligner: shifts the addressed bytes of a 64-bit beat
//   down to bit 0, truncates to the access size and sign/zero-extends.
//   Ports:
//     raw_data  in  DATA_W  read beat as returned by the slave
//     offset    in  3       byte offset within the beat
//     size      in  2       B/H/W/D
//     is_uns    in  1       1 = zero-extend, 0 = sign-extend (ignored for D)
//     ext_data  out DATA_W  aligned, extended result
// ----------------------------------------------------------------------------
module ysyx_22051013_lsu_load_align
  import ysyx_22051013_axi_lsu_read_master_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] raw_data,
  input  logic [2:0]        offset,
  input  logic [1:0]        size,
  input  logic              is_uns,
  output logic [DATA_W-1:0] ext_data
);

  logic [DATA_W-1:0] shifted;

  assign shifted = raw_data >> {offset, 3'b000};

  always_comb begin
    ext_data = shifted;
    unique case (size)
      ysyx_22051013_LS_B: ext_data = is_uns ? {{(DATA_W-8){1'b0}},  shifted[7:0]}
                                            : {{(DATA_W-8){shifted[7]}},  shifted[7:0]};
      ysyx_22051013_LS_H: ext_data = is_uns ? {{(DATA_W-16){1'b0}}, shifted[15:0]}
                                            : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      ysyx_22051013_LS_W: ext_data = is_uns ? {{(DATA_W-32){1'b0}}, shifted[31:0]}
                                            : {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
      default:            ext_data = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_22051013_axi_lsu_read_master.sv
// ----------------------------------------------------------------------------
// ysyx_22051013_axi_lsu_read_master
//   Single-outstanding AXI4-Lite-style read initiator for the LSU. Takes one
//   load from the pipeline, issues a dword-aligned AR beat, extracts and
//   extends the addressed data from the R beat and returns it on a
//   valid/ready response. Misaligned loads are answered with an error
//   without any bus traffic.
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     req_valid/req_ready           load request handshake
//     req_addr/req_size/req_unsigned load attributes
//     resp_valid/resp_ready         result handshake
//     resp_data/resp_err            extended data, error flag
//     lsu_ar_addr/valid/ready       AR channel to the LSU read slave
//     lsu_r_data/resp/valid/ready   R channel from the LSU read slave
// ----------------------------------------------------------------------------
module ysyx_22051013_axi_lsu_read_master
  import ysyx_22051013_axi_lsu_read_master_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] lsu_ar_addr,
  output logic              lsu_ar_valid,
  input  logic              lsu_ar_ready,
  input  logic [DATA_W-1:0] lsu_r_data,
  input  logic [1:0]        lsu_r_resp,
  input  logic              lsu_r_valid,
  output logic              lsu_r_ready
);

  rd_state_e         state_q, state_d;
  ld_meta_t          meta_q, meta_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic              ar_valid_q, ar_valid_d;
  logic              r_ready_q, r_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;
  logic              req_ready_q, req_ready_d;
  logic [DATA_W-1:0] align_data;

  ysyx_22051013_lsu_load_align #(.DATA_W(DATA_W)) u_align (
    .raw_data (lsu_r_data),
    .offset   (meta_q.off),
    .size     (meta_q.size),
    .is_uns   (meta_q.uns),
    .ext_data (align_data)
  );

  // Outputs are the registered copies; next values are set up on the
  // transition into each state so every output is glitch-free.
  always_comb begin
    state_d      = state_q;
    meta_d       = meta_q;
    ar_addr_d    = ar_addr_q;
    ar_valid_d   = ar_valid_q;
    r_ready_d    = r_ready_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    req_ready_d  = req_ready_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          meta_d      = '{off: req_addr[2:0], size: req_size, uns: req_unsigned};
          ar_addr_d   = {req_addr[ADDR_W-1:3], 3'b000};
          req_ready_d = 1'b0;
          resp_err_d  = 1'b0;
          if (ls_misaligned(req_size, req_addr[2:0])) begin
            // Answer directly; the bus never sees this access.
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = '0;
          end else begin
            state_d    = S_ADDR;
            ar_valid_d = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (ar_valid_q && lsu_ar_ready) begin
          state_d    = S_DATA;
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
        end
      end
      S_DATA: begin
        if (lsu_r_valid && r_ready_q) begin
          // Data is returned even on a bus error; resp_err qualifies it.
          state_d      = S_RESP;
          r_ready_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_data_d  = align_data;
          resp_err_d   = (lsu_r_resp != ysyx_22051013_OKAY);
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          // req_ready rises only now, so a waiting request is taken next cycle.
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == ysyx_22051013_RSTABLE) begin
      state_q      <= S_IDLE;
      meta_q       <= '0;
      ar_addr_q    <= '0;
      ar_valid_q   <= 1'b0;
      r_ready_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      meta_q       <= meta_d;
      ar_addr_q    <= ar_addr_d;
      ar_valid_q   <= ar_valid_d;
      r_ready_q    <= r_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_err     = resp_err_q;
  assign lsu_ar_addr  = ar_addr_q;
  assign lsu_ar_valid = ar_valid_q;
  assign lsu_r_ready  = r_ready_q;

endmodule

// File: tb/tb_ysyx_22051013_axi_lsu_read_master.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22051013_axi_lsu_read_master
//   Directed loads against a small behavioural read slave; expected responses
//   and AR addresses are queued at issue time and checked by a monitor.
// ----------------------------------------------------------------------------
module tb_ysyx_22051013_axi_lsu_read_master;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_unsigned;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_data;
  logic [63:0] lsu_ar_addr;
  logic        lsu_ar_valid, lsu_ar_ready;
  logic [63:0] lsu_r_data;
  logic [1:0]  lsu_r_resp;
  logic        lsu_r_valid, lsu_r_ready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t        sb_q[$];
  logic [63:0] ar_q[$];

  // Slave knobs.
  int         ar_stall = 0;
  int         r_delay  = 0;
  logic [1:0] rresp_knob = 2'b00;

  // Monitor statistics.
  int ar_hs = 0, arv_cnt = 0, rv_rise = 0;
  int acc_cyc = 0, ar_hs_cyc = 0, r_hs_cyc = 0, rv_cyc = 0;

  ysyx_22051013_axi_lsu_read_master #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .lsu_ar_addr(lsu_ar_addr), .lsu_ar_valid(lsu_ar_valid), .lsu_ar_ready(lsu_ar_ready),
    .lsu_r_data(lsu_r_data), .lsu_r_resp(lsu_r_resp), .lsu_r_valid(lsu_r_valid),
    .lsu_r_ready(lsu_r_ready)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    case (a)
      64'h8000_0000: return 64'h8877_6655_4433_2211;
      64'h8000_0008: return 64'h0123_4567_89AB_CDEF;
      default:       return 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
  endfunction

  // Behavioural read slave.
  int          s_st = 0, stall_cnt = 0, r_cnt = 0;
  logic [63:0] s_addr;
  always @(posedge clk) begin
    if (rst) begin
      lsu_ar_ready <= 1'b0;
      lsu_r_valid  <= 1'b0;
      lsu_r_data   <= '0;
      lsu_r_resp   <= 2'b00;
      s_st <= 0; stall_cnt <= 0; r_cnt <= 0; s_addr <= '0;
    end else if (s_st == 0) begin
      if (lsu_ar_valid && lsu_ar_ready) begin
        s_st <= 1; lsu_ar_ready <= 1'b0; s_addr <= lsu_ar_addr;
        if (r_delay == 0) begin
          lsu_r_valid <= 1'b1; lsu_r_data <= mem_rd(lsu_ar_addr); lsu_r_resp <= rresp_knob;
        end else r_cnt <= r_delay;
      end else if (lsu_ar_valid) begin
        stall_cnt <= stall_cnt + 1;
        if (stall_cnt + 1 >= ar_stall) lsu_ar_ready <= 1'b1;
      end else begin
        stall_cnt <= 0;
        lsu_ar_ready <= (ar_stall == 0);
      end
    end else begin
      if (lsu_r_valid && lsu_r_ready) begin
        lsu_r_valid <= 1'b0; s_st <= 0; stall_cnt <= 0; lsu_ar_ready <= (ar_stall == 0);
      end else if (!lsu_r_valid) begin
        r_cnt <= r_cnt - 1;
        if (r_cnt <= 1) begin
          lsu_r_valid <= 1'b1; lsu_r_data <= mem_rd(s_addr); lsu_r_resp <= rresp_knob;
        end
      end
    end
  end

  // Monitor: samples just after the falling edge, i.e. the values the next
  // rising edge will act on.
  logic        p_arv = 0, p_arr = 0, p_rv = 0, p_rrdy = 0, p_re = 0;
  logic [63:0] p_ara = '0, p_rd = '0;
  initial forever begin
    @(negedge clk); #1;
    if (!rst) begin
      if (req_valid && req_ready) acc_cyc = cyc;
      if (lsu_ar_valid) arv_cnt++;
      if (p_arv && !p_arr) begin
        chk("ar_valid_hold", {63'd0, lsu_ar_valid}, 64'd1);
        chk("ar_addr_hold", lsu_ar_addr, p_ara);
      end
      if (lsu_ar_valid && lsu_ar_ready) begin
        ar_hs++; ar_hs_cyc = cyc;
        if (ar_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ar_unexpected: got addr %h expected no AR", lsu_ar_addr);
        end else chk("ar_addr", lsu_ar_addr, ar_q.pop_front());
      end
      if (lsu_r_valid && lsu_r_ready) r_hs_cyc = cyc;
      if (resp_valid && !p_rv) begin rv_rise++; rv_cyc = cyc; end
      if (p_rv && !p_rrdy) begin
        chk("resp_valid_hold", {63'd0, resp_valid}, 64'd1);
        chk("resp_data_hold", resp_data, p_rd);
        chk("resp_err_hold", {63'd0, resp_err}, {63'd0, p_re});
      end
      if (resp_valid && resp_ready) begin
        exp_t e;
        chk("req_ready_in_resp", {63'd0, req_ready}, 64'd0);
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_unexpected: got data %h expected no response", resp_data);
        end else begin
          e = sb_q.pop_front();
          chk("resp_data", resp_data, e.data);
          chk("resp_err", {63'd0, resp_err}, {63'd0, e.err});
        end
      end
      p_arv = lsu_ar_valid; p_arr = lsu_ar_ready; p_ara = lsu_ar_addr;
      p_rv = resp_valid; p_rrdy = resp_ready; p_rd = resp_data; p_re = resp_err;
    end else begin
      p_arv = 0; p_arr = 0; p_rv = 0; p_rrdy = 0;
    end
  end

  task automatic issue(input logic [63:0] a, input logic [1:0] sz, input logic u,
                       input logic [63:0] ed, input logic ee, input logic has_ar);
    int n = 0;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_size = sz; req_unsigned = u;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL issue_timeout: got req_ready 0 expected 1 within 200 cycles");
    end else begin
      e.data = ed; e.err = ee;
      sb_q.push_back(e);
      if (has_ar) ar_q.push_back({a[63:3], 3'b000});
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int ar0, arv0, rv0, n;
    rst = 1'b1; req_valid = 0; req_addr = '0; req_size = 0; req_unsigned = 0; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ar_valid", {63'd0, lsu_ar_valid}, 64'd0);
    chk("rst_r_ready", {63'd0, lsu_r_ready}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_ar_addr", lsu_ar_addr, 64'd0);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Byte signed, with latency profile.
    issue(64'h8000_0003, 2'd0, 1'b0, 64'h0000_0000_0000_0044, 1'b0, 1'b1);
    wait_done();
    chk("lat_ar_hs", ar_hs_cyc - acc_cyc, 64'd1);
    chk("lat_r_hs", r_hs_cyc - acc_cyc, 64'd2);
    chk("lat_resp_valid", rv_cyc - acc_cyc, 64'd3);
    chk("idle_req_ready", {63'd0, req_ready}, 64'd1);

    issue(64'h8000_0006, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_8877, 1'b0, 1'b1);
    wait_done();
    issue(64'h8000_0006, 2'd1, 1'b1, 64'h0000_0000_0000_8877, 1'b0, 1'b1);
    wait_done();
    issue(64'h8000_0000, 2'd3, 1'b0, 64'h8877_6655_4433_2211, 1'b0, 1'b1);
    wait_done();

    // Misaligned word: no AR, immediate error response.
    arv0 = arv_cnt; ar0 = ar_hs;
    issue(64'h8000_0002, 2'd2, 1'b0, 64'd0, 1'b1, 1'b0);
    wait_done();
    chk("mis_no_ar_valid", arv_cnt - arv0, 64'd0);
    chk("mis_no_ar_hs", ar_hs - ar0, 64'd0);
    chk("mis_resp_latency", rv_cyc - acc_cyc, 64'd1);

    // Slave stalls on AR then R.
    ar_stall = 3; r_delay = 2;
    @(negedge clk);
    arv0 = arv_cnt; ar0 = ar_hs; rv0 = rv_rise;
    issue(64'h8000_0000, 2'd2, 1'b1, 64'h0000_0000_4433_2211, 1'b0, 1'b1);
    wait_done();
    chk("stall_ar_valid_cycles", arv_cnt - arv0, 64'd4);
    chk("stall_one_ar", ar_hs - ar0, 64'd1);
    chk("stall_one_resp", rv_rise - rv0, 64'd1);
    ar_stall = 0; r_delay = 0;
    @(negedge clk);

    // Response back-pressure with a waiting request.
    resp_ready = 1'b0;
    issue(64'h8000_0007, 2'd0, 1'b1, 64'h0000_0000_0000_0088, 1'b0, 1'b1);
    n = 0;
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_resp_seen", {63'd0, resp_valid}, 64'd1);
    req_valid = 1'b1; req_addr = 64'h8000_0002; req_size = 2'd1; req_unsigned = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("bp_req_ready_low", {63'd0, req_ready}, 64'd0);
    end
    begin
      exp_t e;
      e.data = 64'h0000_0000_0000_4433; e.err = 1'b0;
      sb_q.push_back(e);
      ar_q.push_back(64'h8000_0000);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ret_req_ready", {63'd0, req_ready}, 64'd1);
    chk("bp_ret_resp_valid", {63'd0, resp_valid}, 64'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_accepted", {63'd0, req_ready}, 64'd0);
    wait_done();

    // Bus error response still carries data.
    rresp_knob = 2'b10;
    issue(64'h8000_0004, 2'd2, 1'b0, 64'hFFFF_FFFF_8877_6655, 1'b1, 1'b1);
    wait_done();
    rresp_knob = 2'b00;

    // Reset while waiting for R.
    r_delay = 5;
    @(negedge clk);
    issue(64'h8000_0000, 2'd3, 1'b0, 64'd0, 1'b0, 1'b1);
    n = 0;
    while (!lsu_r_ready && n < 50) begin @(negedge clk); n++; end
    chk("mid_in_data", {63'd0, lsu_r_ready}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_r_ready", {63'd0, lsu_r_ready}, 64'd0);
    chk("mid_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("mid_rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("mid_rst_ar_valid", {63'd0, lsu_ar_valid}, 64'd0);
    rst = 1'b0; r_delay = 0;
    sb_q.delete(); ar_q.delete();
    @(negedge clk);
    issue(64'h8000_000B, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF89, 1'b0, 1'b1);
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
